spi_flash_read_master: RTL and testbench

SPI mode-0 master that fetches 32-bit words from a standard serial NOR flash using the READ (0x03) command and a 24-bit byte address. It sits between the program loader and the board's configuration flash. The host gives it an address with a one-cycle strobe. The block returns the 4 data bytes big-endian through a valid/acknowledge handshake. After reset it wakes the flash from deep power-down before accepting any request.

---
 rtl/spi_flash_pkg.sv | 17 +
 rtl/spi_bit_engine.sv | 75 +++++++
 rtl/spi_flash_read_master.sv | 132 +++++++++++++
 tb/tb_spi_flash_read_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, frame sizes and FSM state encoding for the SPI flash read master.
package spi_flash_pkg;

   localparam logic [7:0]  CMD_READ  = 8'h03;
   localparam logic [7:0]  CMD_WAKE  = 8'hAB;
   localparam int unsigned XFER_BITS = 64;
   localparam int unsigned WAKE_BITS = 8;

   typedef enum logic [2:0] {
      WAKE_CMD,
      WAKE_WAIT,
      IDLE,
      XFER,
      DONE
   } state_t;

endpackage

// File: rtl/spi_bit_engine.sv
// Mode-0 SPI bit engine: SCK prescaler, MSB-first MOSI shifter, MISO capture.
// done pulses combinationally on the clk edge that ends the final SCK-high phase.
module spi_bit_engine
   import spi_flash_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic [$clog2(XFER_BITS+1)-1:0]     nbits,
   input  logic [XFER_BITS-1:0]               tx_word,
   input  logic                               miso,
   output logic                               sck,
   output logic                               mosi,
   output logic                               busy,
   output logic                               done,
   output logic [31:0]                        rx_word
);

   localparam int unsigned NBW = $clog2(XFER_BITS + 1);
   localparam int unsigned DW  = $clog2(CLK_DIV + 1);

   logic [DW-1:0]        div_cnt;
   logic [NBW-1:0]       bit_cnt;
   logic [XFER_BITS-1:0] tx_sr;
   logic [31:0]          rx_sr;
   logic                 sck_q;
   logic                 busy_q;
   logic                 phase_end;

   assign phase_end = (div_cnt == '0);
   assign done      = busy_q && sck_q && phase_end && (bit_cnt == NBW'(1));
   assign sck       = sck_q;
   assign busy      = busy_q;
   assign mosi      = busy_q ? tx_sr[XFER_BITS-1] : 1'b0;
   assign rx_word   = rx_sr;

   // The start cycle adds one extra low cycle before the first SCK edge, so MOSI
   // and SS have settled; later bits get exactly CLK_DIV low cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         sck_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else if (start) begin
         busy_q  <= 1'b1;
         sck_q   <= 1'b0;
         tx_sr   <= tx_word;
         bit_cnt <= nbits;
         div_cnt <= DW'(CLK_DIV);
      end else if (busy_q) begin
         if (!phase_end) begin
            div_cnt <= div_cnt - 1'b1;
         end else begin
            div_cnt <= DW'(CLK_DIV - 1);
            if (!sck_q) begin
               sck_q <= 1'b1;
               if (bit_cnt <= NBW'(32))
                  rx_sr <= {rx_sr[30:0], miso};
            end else begin
               sck_q   <= 1'b0;
               tx_sr   <= {tx_sr[XFER_BITS-2:0], 1'b0};
               bit_cnt <= bit_cnt - 1'b1;
               if (bit_cnt == NBW'(1))
                  busy_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/spi_flash_read_master.sv
// Fetches 32-bit big-endian words from a serial NOR flash with READ (0x03),
// after waking the flash from deep power-down (0xAB) following reset.
module spi_flash_read_master #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned WAKE_WAIT = 48
) (
   input  logic        clk,
   input  logic        reset,
   output logic        SPI_SCK,
   output logic        SPI_SS,
   output logic        SPI_MOSI,
   input  logic        SPI_MISO,
   output logic        addr_buffer_free,
   input  logic        addr_en,
   input  logic [23:0] addr_data,
   output logic        rd_data_available,
   input  logic        rd_ack,
   output logic [31:0] rd_data
);

   import spi_flash_pkg::*;

   localparam int unsigned NBW = $clog2(XFER_BITS + 1);
   localparam int unsigned WCW = (WAKE_WAIT > 1) ? $clog2(WAKE_WAIT) : 1;

   state_t               state, state_nx;
   logic                 ss_q, ss_nx;
   logic                 avail_q, avail_nx;
   logic [31:0]          data_q;
   logic                 load_data;
   logic [WCW-1:0]       wait_q, wait_nx;

   logic                 eng_start;
   logic [NBW-1:0]       eng_nbits;
   logic [XFER_BITS-1:0] eng_tx;
   logic                 eng_busy;
   logic                 eng_done;
   logic [31:0]          eng_rx;

   spi_bit_engine #(
      .CLK_DIV (CLK_DIV)
   ) u_engine (
      .clk     (clk),
      .reset   (reset),
      .start   (eng_start),
      .nbits   (eng_nbits),
      .tx_word (eng_tx),
      .miso    (SPI_MISO),
      .sck     (SPI_SCK),
      .mosi    (SPI_MOSI),
      .busy    (eng_busy),
      .done    (eng_done),
      .rx_word (eng_rx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= WAKE_CMD;
         ss_q    <= 1'b1;
         avail_q <= 1'b0;
         data_q  <= '0;
         wait_q  <= '0;
      end else begin
         state   <= state_nx;
         ss_q    <= ss_nx;
         avail_q <= avail_nx;
         wait_q  <= wait_nx;
         if (load_data)
            data_q <= eng_rx;
      end
   end

   // WAKE_WAIT the state is named through the package: the parameter shadows it here.
   always_comb begin
      state_nx  = state;
      ss_nx     = ss_q;
      avail_nx  = avail_q;
      wait_nx   = wait_q;
      load_data = 1'b0;
      eng_start = 1'b0;
      eng_nbits = NBW'(XFER_BITS);
      eng_tx    = {CMD_READ, addr_data, 32'h0};
      case (state)
         WAKE_CMD: begin
            eng_nbits = NBW'(WAKE_BITS);
            eng_tx    = {CMD_WAKE, {(XFER_BITS-8){1'b0}}};
            if (ss_q && !eng_busy) begin
               eng_start = 1'b1;
               ss_nx     = 1'b0;
            end else if (eng_done) begin
               ss_nx    = 1'b1;
               wait_nx  = '0;
               state_nx = spi_flash_pkg::WAKE_WAIT;
            end
         end
         spi_flash_pkg::WAKE_WAIT: begin
            if (wait_q == WCW'(WAKE_WAIT - 1))
               state_nx = IDLE;
            else
               wait_nx = wait_q + 1'b1;
         end
         IDLE: begin
            if (addr_en) begin
               eng_start = 1'b1;
               ss_nx     = 1'b0;
               state_nx  = XFER;
            end
         end
         XFER: begin
            if (eng_done) begin
               ss_nx     = 1'b1;
               load_data = 1'b1;
               avail_nx  = 1'b1;
               state_nx  = DONE;
            end
         end
         DONE: begin
            if (rd_ack) begin
               avail_nx = 1'b0;
               state_nx = IDLE;
            end
         end
         default: state_nx = WAKE_CMD;
      endcase
   end

   assign SPI_SS            = ss_q;
   assign addr_buffer_free  = (state == IDLE);
   assign rd_data_available = avail_q;
   assign rd_data           = data_q;

endmodule

// File: tb/tb_spi_flash_read_master.sv
// Self-checking bench: behavioural NOR flash on the SPI pins plus a word-level
// reference model of expected frames, data and handshake timing.
module tb_spi_flash_read_master;

   localparam int unsigned CLK_DIV_P   = 2;
   localparam int unsigned WAKE_WAIT_P = 48;
   localparam int          LATENCY     = 1 + 128 * CLK_DIV_P;

   logic        clk = 1'b0;
   logic        reset;
   logic        SPI_SCK, SPI_SS, SPI_MOSI;
   logic        SPI_MISO = 1'b0;
   logic        addr_buffer_free;
   logic        addr_en;
   logic [23:0] addr_data;
   logic        rd_data_available;
   logic        rd_ack;
   logic [31:0] rd_data;

   spi_flash_read_master #(
      .CLK_DIV   (CLK_DIV_P),
      .WAKE_WAIT (WAKE_WAIT_P)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .SPI_SCK           (SPI_SCK),
      .SPI_SS            (SPI_SS),
      .SPI_MOSI          (SPI_MOSI),
      .SPI_MISO          (SPI_MISO),
      .addr_buffer_free  (addr_buffer_free),
      .addr_en           (addr_en),
      .addr_data         (addr_data),
      .rd_data_available (rd_data_available),
      .rd_ack            (rd_ack),
      .rd_data           (rd_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Flash content: explicit bytes where a test needs them, a hash elsewhere.
   logic [7:0] mem [logic [23:0]];

   function automatic logic [7:0] byte_at(input logic [23:0] a);
      if (mem.exists(a))
         return mem[a];
      return a[7:0] ^ a[15:8] ^ (a[23:16] + 8'h5A);
   endfunction

   function automatic logic [31:0] model_word(input logic [23:0] a);
      return {byte_at(a), byte_at(a + 24'd1), byte_at(a + 24'd2), byte_at(a + 24'd3)};
   endfunction

   typedef struct {
      int          nb;
      logic [63:0] bits;
   } frame_t;

   frame_t      frames[$];
   int          starts = 0, ends = 0;
   int          bitcnt = 0;
   logic [63:0] shift_in = '0;
   logic        last_mosi = 1'b0;
   logic [31:0] resp = '0;
   int          glitches = 0;

   always @(negedge SPI_SS or posedge SPI_SCK) begin
      if (SPI_SCK === 1'b1) begin
         if (SPI_SS === 1'b0) begin
            shift_in  = {shift_in[62:0], SPI_MOSI};
            last_mosi = SPI_MOSI;
            bitcnt++;
         end
      end else begin
         starts++;
         bitcnt   = 0;
         shift_in = '0;
      end
   end

   always @(posedge SPI_SS) begin
      if (starts != ends) begin
         ends = starts;
         frames.push_back('{nb: bitcnt, bits: shift_in});
      end
   end

   // Flash shifts data out on SCK falling edges once command and address are in.
   always @(negedge SPI_SCK) begin
      if (SPI_SS === 1'b0 && bitcnt >= 32 && bitcnt < 64) begin
         if (bitcnt == 32)
            resp = model_word(shift_in[23:0]);
         SPI_MISO = resp[63 - bitcnt];
      end else begin
         SPI_MISO = 1'($urandom);
      end
   end

   always @(negedge clk) begin
      if (SPI_SS === 1'b0 && SPI_SCK === 1'b1 && SPI_MOSI !== last_mosi)
         glitches++;
   end

   task automatic pop_frame(output frame_t fr);
      if (frames.size() == 0) begin
         check("frame_present", 64'(0), 64'(1));
         fr = '{nb: -1, bits: '0};
      end else begin
         fr = frames.pop_front();
      end
   endtask

   task automatic wake_check();
      int     n;
      frame_t fr;
      n = 0;
      while (SPI_SS === 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("wake_ss_low", 64'(SPI_SS), 64'(0));
      n = 0;
      while (SPI_SS === 1'b0 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("wake_ss_high", 64'(SPI_SS), 64'(1));
      check("wake_sck_idle", 64'(SPI_SCK), 64'(0));
      n = 0;
      while (addr_buffer_free !== 1'b1 && n < 500) begin
         addr_en   = (n == 10);
         addr_data = 24'hABCDEF;
         @(posedge clk); #1; n++;
      end
      addr_en = 1'b0;
      check("wake_wait_len", 64'(n), 64'(WAKE_WAIT_P));
      pop_frame(fr);
      check("wake_nbits", 64'(fr.nb), 64'(8));
      check("wake_opcode", 64'(fr.bits[7:0]), 64'(8'hAB));
      repeat (2) @(posedge clk);
      #1;
      check("wake_no_extra", 64'(frames.size()), 64'(0));
      check("wake_ss_idle", 64'(SPI_SS), 64'(1));
   endtask

   task automatic do_read(input logic [23:0] a, input int hold, input bit inject);
      logic [31:0] exp;
      int          lat;
      frame_t      fr;
      exp = model_word(a);
      @(posedge clk); #1;
      check("free_before", 64'(addr_buffer_free), 64'(1));
      addr_data = a;
      addr_en   = 1'b1;
      @(posedge clk); #1;
      addr_en   = 1'b0;
      addr_data = 24'($urandom);
      check("free_busy", 64'(addr_buffer_free), 64'(0));
      check("ss_active", 64'(SPI_SS), 64'(0));
      lat = 0;
      do begin
         addr_en = inject && (lat == 60);
         if (addr_en)
            addr_data = ~a;
         @(posedge clk); #1; lat++;
      end while (rd_data_available !== 1'b1 && lat < 2000);
      addr_en = 1'b0;
      check("latency", 64'(lat), 64'(LATENCY));
      check("rd_data", 64'(rd_data), 64'(exp));
      check("ss_done", 64'({SPI_SS, SPI_SCK}), 64'(2'b10));
      for (int i = 0; i < hold; i++) begin
         addr_en = inject && (i == 3);
         @(posedge clk); #1;
         addr_en = 1'b0;
         check("hold", 64'({rd_data_available, SPI_SS, addr_buffer_free, rd_data}),
               64'({1'b1, 1'b1, 1'b0, exp}));
      end
      rd_ack = 1'b1;
      @(posedge clk); #1;
      rd_ack = 1'b0;
      check("ack_release", 64'({rd_data_available, addr_buffer_free, SPI_SS}), 64'(3'b011));
      pop_frame(fr);
      check("frame_nbits", 64'(fr.nb), 64'(64));
      check("frame_cmd_addr", 64'(fr.bits[63:32]), 64'({8'h03, a}));
      check("frame_mosi_data_zero", 64'(fr.bits[31:0]), 64'(0));
      if (inject) begin
         repeat (3) @(posedge clk);
         #1;
         check("no_extra_frame", 64'({frames.size(), SPI_SS}), 64'({32'd0, 1'b1}));
      end
   endtask

   task automatic abort_test(input logic [23:0] a);
      frame_t fr;
      @(posedge clk); #1;
      addr_data = a;
      addr_en   = 1'b1;
      @(posedge clk); #1;
      addr_en = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_pins", 64'({SPI_SS, SPI_SCK, SPI_MOSI}), 64'(3'b100));
      check("abort_outputs", 64'({rd_data_available, addr_buffer_free, rd_data}), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_no_data", 64'(rd_data_available), 64'(0));
      pop_frame(fr);
      check("abort_partial", 64'(fr.nb < 64), 64'(1));
      wake_check();
   endtask

   initial begin
      reset     = 1'b1;
      addr_en   = 1'b0;
      addr_data = '0;
      rd_ack    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sck", 64'(SPI_SCK), 64'(0));
      check("rst_ss", 64'(SPI_SS), 64'(1));
      check("rst_mosi", 64'(SPI_MOSI), 64'(0));
      check("rst_free", 64'(addr_buffer_free), 64'(0));
      check("rst_avail", 64'(rd_data_available), 64'(0));
      check("rst_data", 64'(rd_data), 64'(0));
      rd_ack = 1'b1;
      @(posedge clk); #1;
      rd_ack = 1'b0;
      reset  = 1'b0;
      wake_check();

      mem[24'h100000] = 8'h12;
      mem[24'h100001] = 8'h34;
      mem[24'h100002] = 8'h56;
      mem[24'h100003] = 8'h78;
      check("model_known_word", 64'(model_word(24'h100000)), 64'(32'h12345678));
      do_read(24'h100000, 20, 1'b0);
      do_read(24'h0FFFFC, 8, 1'b1);
      do_read(24'h103000, 0, 1'b0);
      do_read(24'h103004, 0, 1'b0);
      do_read(24'hFFFFFE, 1, 1'b0);
      for (int k = 0; k < 6; k++)
         do_read(24'($urandom), $urandom_range(0, 6), 1'b0);
      abort_test(24'h055AA0);
      do_read(24'h100000, 2, 1'b0);
      check("mosi_stable_sck_high", 64'(glitches), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
